// File: rtl/io_input_debouncer.sv
// io_input_debouncer
//   Conditions raw board switches and pushbuttons before they reach the
//   data-memory/I/O block. Every bit gets a two-flop synchroniser followed by
//   its own saturating debounce counter. The debounced level only flips once
//   the synchronised input has disagreed with it for DEBOUNCE_CYCLES
//   consecutive cycles. Key press/release edges are reported as one-cycle
//   pulses.
//
// Ports
//   CLK        in   system clock, all state updates on rising edge
//   RESET_N    in   asynchronous active-low reset
//   SW         in   [NSW]  raw switches, async to CLK, active-high
//   KEY        in   [NKEY] raw pushbuttons, async to CLK, active-low
//   SW_DB      out  [NSW]  debounced switches, active-high
//   KEY_DB     out  [NKEY] debounced keys, active-low
//   KEY_PRESS  out  [NKEY] one-cycle pulse when KEY_DB[i] goes 1->0
//   KEY_REL    out  [NKEY] one-cycle pulse when KEY_DB[i] goes 0->1
module io_input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNTBITS         = 20,
  parameter int unsigned NSW             = 10,
  parameter int unsigned NKEY            = 4
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [NSW-1:0]  SW,
  input  logic [NKEY-1:0] KEY,
  output logic [NSW-1:0]  SW_DB,
  output logic [NKEY-1:0] KEY_DB,
  output logic [NKEY-1:0] KEY_PRESS,
  output logic [NKEY-1:0] KEY_REL
);

  // Switches and keys share one datapath: bits [NSW-1:0] are switches,
  // bits [N-1:NSW] are keys. Only the reset level differs between the two
  // groups (switches idle low, keys idle high = released).
  localparam int unsigned N = NSW + NKEY;
  localparam logic [N-1:0] RST_VAL = {{NKEY{1'b1}}, {NSW{1'b0}}};
  localparam logic [CNTBITS-1:0] CNT_MAX = CNTBITS'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]       raw;
  logic [N-1:0]       sync1_q;
  logic [N-1:0]       sync2_q;
  logic [N-1:0]       db_q;
  logic [N-1:0]       db_d;
  logic [CNTBITS-1:0] cnt_q [N];
  logic [CNTBITS-1:0] cnt_d [N];
  logic [NKEY-1:0]    press_q;
  logic [NKEY-1:0]    press_d;
  logic [NKEY-1:0]    rel_q;
  logic [NKEY-1:0]    rel_d;

  assign raw = {KEY, SW};

  // Two-stage synchroniser; sync2_q is the synchronised input seen by the
  // debounce logic.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce. Any agreement between the synchronised input and the
  // debounced level clears the count (no partial credit); the counter is
  // bounded by the terminal compare, so it never wraps.
  always_comb begin
    db_d = db_q;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNTBITS'(1);
      end
    end
  end

  // Pulses are registered alongside the key level they describe, so a pulse
  // appears on the same edge that flips KEY_DB.
  always_comb begin
    press_d = db_q[N-1:NSW] & ~db_d[N-1:NSW];
    rel_d   = ~db_q[N-1:NSW] & db_d[N-1:NSW];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      db_q    <= RST_VAL;
      press_q <= '0;
      rel_q   <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q    <= db_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign SW_DB     = db_q[NSW-1:0];
  assign KEY_DB    = db_q[N-1:NSW];
  assign KEY_PRESS = press_q;
  assign KEY_REL   = rel_q;

endmodule

// File: tb/tb_io_input_debouncer.sv
module tb_io_input_debouncer;

  localparam int unsigned BIG_CYCLES = 20000;

  logic       clk;
  logic       rst_n;
  logic [9:0] sw;
  logic [3:0] key;
  logic [9:0] sw_db;
  logic [3:0] key_db;
  logic [3:0] key_press;
  logic [3:0] key_rel;

  logic [9:0] sw_b;
  logic [3:0] key_b;
  logic [9:0] sw_db_b;
  logic [3:0] key_db_b;
  logic [3:0] key_press_b;
  logic [3:0] key_rel_b;

  int n_checks = 0;
  int n_fail   = 0;

  io_input_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNTBITS(20),
    .NSW(10),
    .NKEY(4)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .SW(sw),
    .KEY(key),
    .SW_DB(sw_db),
    .KEY_DB(key_db),
    .KEY_PRESS(key_press),
    .KEY_REL(key_rel)
  );

  io_input_debouncer #(
    .DEBOUNCE_CYCLES(BIG_CYCLES),
    .CNTBITS(20),
    .NSW(10),
    .NKEY(4)
  ) dut_big (
    .CLK(clk),
    .RESET_N(rst_n),
    .SW(sw_b),
    .KEY(key_b),
    .SW_DB(sw_db_b),
    .KEY_DB(key_db_b),
    .KEY_PRESS(key_press_b),
    .KEY_REL(key_rel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int rise_edge;

    // Reset with inputs opposite to the reset levels.
    rst_n = 1'b0;
    sw    = 10'h3FF;
    key   = 4'h0;
    sw_b  = 10'h000;
    key_b = 4'hF;
    ticks(3);
    check("rst_sw_db", 32'(sw_db), 32'h000);
    check("rst_key_db", 32'(key_db), 32'hF);
    check("rst_press", 32'(key_press), 32'h0);
    check("rst_rel", 32'(key_rel), 32'h0);

    rst_n = 1'b1;
    ticks(5);
    check("rst_e5_sw_db", 32'(sw_db), 32'h000);
    check("rst_e5_key_db", 32'(key_db), 32'hF);
    check("rst_e5_press", 32'(key_press), 32'h0);
    tick();
    check("rst_e6_sw_db", 32'(sw_db), 32'h3FF);
    check("rst_e6_key_db", 32'(key_db), 32'h0);
    check("rst_e6_press", 32'(key_press), 32'hF);
    tick();
    check("rst_e7_press", 32'(key_press), 32'h0);

    // Return everything to idle; all keys release together.
    sw  = 10'h000;
    key = 4'hF;
    ticks(6);
    check("idle_rel", 32'(key_rel), 32'hF);
    check("idle_sw_db", 32'(sw_db), 32'h000);
    tick();
    check("idle_rel_clr", 32'(key_rel), 32'h0);
    check("idle_key_db", 32'(key_db), 32'hF);

    // Clean press of KEY[2].
    key = 4'hB;
    ticks(5);
    check("press_e5_db", 32'(key_db), 32'hF);
    tick();
    check("press_e6_db", 32'(key_db), 32'hB);
    check("press_e6_pulse", 32'(key_press), 32'h4);
    check("press_e6_rel", 32'(key_rel), 32'h0);
    tick();
    check("press_e7_pulse", 32'(key_press), 32'h0);
    ticks(3);

    // Release of KEY[2].
    key = 4'hF;
    ticks(5);
    check("rel_e5_db", 32'(key_db), 32'hB);
    tick();
    check("rel_e6_db", 32'(key_db), 32'hF);
    check("rel_e6_pulse", 32'(key_rel), 32'h4);
    check("rel_e6_press", 32'(key_press), 32'h0);
    tick();
    check("rel_e7_pulse", 32'(key_rel), 32'h0);

    // Bounce on SW[5]: 3-cycle highs never reach the debounce threshold.
    for (int b = 0; b < 5; b++) begin
      sw = 10'h020;
      ticks(3);
      sw = 10'h000;
      ticks(3);
      check("bounce_sw_db", 32'(sw_db), 32'h000);
    end
    ticks(2);
    check("bounce_settle", 32'(sw_db), 32'h000);
    sw = 10'h020;
    ticks(5);
    check("bounce_e5", 32'(sw_db), 32'h000);
    tick();
    check("bounce_e6", 32'(sw_db), 32'h020);
    sw = 10'h000;
    ticks(8);
    check("bounce_back", 32'(sw_db), 32'h000);

    // Simultaneous: KEY[0] and KEY[3] drop while SW jumps to 2A5.
    key = 4'h6;
    sw  = 10'h2A5;
    ticks(5);
    check("sim_e5_key_db", 32'(key_db), 32'hF);
    check("sim_e5_sw_db", 32'(sw_db), 32'h000);
    tick();
    check("sim_e6_press", 32'(key_press), 32'h9);
    check("sim_e6_key_db", 32'(key_db), 32'h6);
    check("sim_e6_sw_db", 32'(sw_db), 32'h2A5);
    tick();
    check("sim_e7_press", 32'(key_press), 32'h0);
    key = 4'hF;
    sw  = 10'h000;
    ticks(8);
    check("sim_idle", 32'({sw_db, key_db}), 32'({10'h000, 4'hF}));

    // Async reset mid-count: KEY[0] debounced low, SW[0] high, then KEY[1]
    // drops and reset hits with its counter at 2, between clock edges.
    key = 4'hE;
    sw  = 10'h001;
    ticks(8);
    check("ar_pre_key_db", 32'(key_db), 32'hE);
    check("ar_pre_sw_db", 32'(sw_db), 32'h001);
    key = 4'hC;
    ticks(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_now_key_db", 32'(key_db), 32'hF);
    check("ar_now_sw_db", 32'(sw_db), 32'h000);
    check("ar_now_press", 32'(key_press), 32'h0);
    ticks(3);
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("ar_no_pulse", 32'(key_press), 32'h0);
    end
    tick();
    check("ar_e6_press", 32'(key_press), 32'h3);
    check("ar_e6_key_db", 32'(key_db), 32'hC);
    check("ar_e6_sw_db", 32'(sw_db), 32'h001);
    tick();
    check("ar_e7_press", 32'(key_press), 32'h0);

    // Large threshold: SW[0] must rise exactly on edge BIG_CYCLES+2.
    sw_b = 10'h001;
    rise_edge = 0;
    for (int e = 1; e <= BIG_CYCLES + 2; e++) begin
      tick();
      if (sw_db_b[0] && rise_edge == 0) rise_edge = e;
    end
    check("big_rise_edge", 32'(rise_edge), 32'(BIG_CYCLES + 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
